dp_ram_fifo_ctrl: RTL and testbench
===================================

Name: dp_ram_fifo_ctrl

Overview:
- Synchronous FIFO controller that sits directly upstream of the team's dual-port RAM.
- Turns a push/pop request interface into RAM write and read commands: addresses, enables and write data.
- Tracks pointers and occupancy, and raises full, empty, almost-full and error flags.
- Read data comes from the RAM's registered output one cycle after a pop. This block issues a pop_valid strobe aligned with that data.

Parameters:
- ADDR_WIDTH, 8: RAM address width. FIFO depth is 2**ADDR_WIDTH.
- DATA_WIDTH, 32: width of the push data and the RAM data.
- AF_LEVEL, 2**ADDR_WIDTH-2: almost_full asserts when count >= AF_LEVEL. Legal range is 1..depth.

Ports:
- clk_in  input  1  clock; all logic is on the rising edge
- rst_n_in  input  1  asynchronous active-low reset
- clr  input  1  synchronous clear of all pointers and flags
- push  input  1  write request
- push_data  input  DATA_WIDTH  data to enqueue
- pop  input  1  read request
- full  output  1  count == depth
- empty  output  1  count == 0
- almost_full  output  1  count >= AF_LEVEL
- count  output  ADDR_WIDTH+1  current occupancy, 0..depth
- overflow  output  1  sticky: push seen while full
- underflow  output  1  sticky: pop seen while empty
- pop_valid  output  1  the RAM's data_out holds the popped word this cycle
- ram_wr_en  output  1  RAM write enable
- ram_wr_addr  output  ADDR_WIDTH  RAM write address
- ram_wr_data  output  DATA_WIDTH  RAM write data
- ram_rd_en  output  1  RAM read enable
- ram_rd_addr  output  ADDR_WIDTH  RAM read address

Behaviour:
- Clock and reset: one clock, clk_in. Reset rst_n_in is asynchronous and active-low.
- Reset values: wr_ptr = 0, rd_ptr = 0, count = 0, empty = 1, full = 0, almost_full = 0, overflow = 0, underflow = 0, pop_valid = 0.
- Pointers:
  - wr_ptr and rd_ptr are ADDR_WIDTH+1 bits wide.
  - The RAM address is the low ADDR_WIDTH bits. The MSB is the wrap bit.
  - Pointers wrap naturally from 2**(ADDR_WIDTH+1)-1 to 0.
- Accept rules, evaluated on registered state at the start of the cycle:
  - push_acc = push & ~full
  - pop_acc = pop & ~empty
- RAM command outputs are combinational from the current state and request inputs:
  - ram_wr_en = push_acc, ram_wr_addr = wr_ptr[ADDR_WIDTH-1:0], ram_wr_data = push_data.
  - ram_rd_en = pop_acc, ram_rd_addr = rd_ptr[ADDR_WIDTH-1:0].
- Pointer and count update on a clock edge:
  - On push_acc: wr_ptr + 1.
  - On pop_acc: rd_ptr + 1.
  - Count changes by +1, -1 or 0 (0 when both are accepted).
- Flags: full, empty and almost_full are registered. They are derived from the next-state count so they are valid in the same cycle as count.
- pop_valid is registered: pop_valid <= pop_acc. This gives 1-cycle latency, matching the RAM's registered read.
- Simultaneous push and pop:
  - Full: pop accepted, push rejected (full is not re-evaluated mid-cycle). overflow sets.
  - Empty: push accepted, pop rejected (no fall-through). underflow sets.
  - Otherwise: both accepted, count unchanged.
- Read/write address collision: impossible while count is between 1 and depth-1. Full blocks writes to the unread head, and empty blocks reads, so the RAM never sees a read and write to the same live address.
- Error flags: overflow sets on push & full, and underflow sets on pop & empty. Both stay set until clr or reset.
- clr:
  - Same-cycle effect: pointers, count, error flags and pop_valid return to reset values on the next edge.
  - Requests: push and pop in the same cycle as clr are ignored, and ram_wr_en and ram_rd_en are forced to 0.
  - Priority: clr takes priority over all other updates.
- Reset mid-operation: all state clears immediately, and ram_wr_en and ram_rd_en drop to 0 combinationally. RAM contents are not this block's concern.

Decomposition:
- Shared package fifo_pkg holds:
  - the occupancy type and pointer width function (ADDR_WIDTH+1)
  - a localparam for DEPTH
- One natural sub-module: fifo_ptr, holding the pointer register plus its wrap logic, instantiated twice (write and read).
- A top-level integration wrapper (dp_ram_fifo) instantiates this block and the dual-port RAM. It is a separate file and not part of this spec.

Test Plan (ADDR_WIDTH=3, DATA_WIDTH=32, AF_LEVEL=6, RAM model attached):
- Reset check: after reset, no requests -> empty=1, full=0, count=0, pop_valid=0, ram_wr_en=0, ram_rd_en=0.
- Fill and drain: push 0xA0..0xA7 on 8 consecutive cycles -> count=8, full=1, almost_full first seen after the 6th push. Then pop 8 times -> pop_valid one cycle after each pop, RAM data_out sequence 0xA0..0xA7, empty=1 at the end.
- Wrap-around: push 5, pop 5, then push 8 (0xB0..0xB7) and pop 8 -> addresses wrap 7->0, data_out 0xB0..0xB7 in order, count returns to 0.
- Simultaneous requests:
  - At count=3, push+pop for 4 cycles -> count stays 3, order preserved.
  - At full, push+pop -> count=7, overflow=1.
  - At empty, push+pop -> count=1, underflow=1, pop_valid=0 next cycle.
- Error and clear: pop when empty -> underflow=1, which persists until clr. clr at count=4 with push asserted -> count=0, empty=1, ram_wr_en=0 that cycle, flags=0.
- Reset mid-stream: assert rst_n_in low asynchronously between edges at count=5 -> count=0, empty=1, pop_valid=0 immediately. First push after release writes RAM address 0.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared types and helpers for the dual-port-RAM FIFO controller.
package fifo_pkg;

  localparam int unsigned ADDR_WIDTH_DEFAULT = 8;
  localparam int unsigned DEPTH              = 2 ** ADDR_WIDTH_DEFAULT;

  // Occupancy needs one more bit than the address to represent a full FIFO.
  typedef logic [ADDR_WIDTH_DEFAULT:0] occ_t;

  function automatic int unsigned ptr_width(input int unsigned addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// FIFO pointer register: increments on request, wraps naturally through the extra MSB.
module fifo_ptr #(
  parameter int unsigned WIDTH = 9
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             clr,
  input  logic             inc,
  output logic [WIDTH-1:0] ptr
);

  localparam logic [WIDTH-1:0] One = WIDTH'(1);

  logic [WIDTH-1:0] ptr_d, ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (clr) begin
      ptr_d = '0;
    end else if (inc) begin
      ptr_d = ptr_q + One;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/dp_ram_fifo_ctrl.sv
// FIFO controller driving a dual-port RAM: pointers, occupancy, flags and RAM commands.
module dp_ram_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEFAULT,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned AF_LEVEL   = 2 ** ADDR_WIDTH - 2
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  clr,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  pop_valid,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic                  ram_rd_en,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr
);

  localparam int unsigned   PW      = ptr_width(ADDR_WIDTH);
  localparam logic [PW-1:0] One     = PW'(1);
  localparam logic [PW-1:0] DepthC  = PW'(2 ** ADDR_WIDTH);
  localparam logic [PW-1:0] AfLevel = PW'(AF_LEVEL);

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW-1:0] count_d, count_q;
  logic          full_d, full_q, empty_d, empty_q, af_d, af_q;
  logic          ovf_d, ovf_q, udf_d, udf_q, pv_q;
  logic          push_acc, pop_acc;

  // Gating with rst_n_in drops RAM enables the moment reset asserts, not at the next edge.
  assign push_acc = push & ~full_q & ~clr & rst_n_in;
  assign pop_acc  = pop & ~empty_q & ~clr & rst_n_in;

  fifo_ptr #(.WIDTH(PW)) u_wr_ptr (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .clr      (clr),
    .inc      (push_acc),
    .ptr      (wr_ptr)
  );

  fifo_ptr #(.WIDTH(PW)) u_rd_ptr (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .clr      (clr),
    .inc      (pop_acc),
    .ptr      (rd_ptr)
  );

  always_comb begin
    count_d = count_q;
    unique case ({push_acc, pop_acc})
      2'b10:   count_d = count_q + One;
      2'b01:   count_d = count_q - One;
      default: count_d = count_q;
    endcase
    if (clr) begin
      count_d = '0;
    end
    // Flags follow next-state count so they line up with the registered count.
    full_d  = (count_d == DepthC);
    empty_d = (count_d == '0);
    af_d    = (count_d >= AfLevel);
    ovf_d   = clr ? 1'b0 : (ovf_q | (push & full_q));
    udf_d   = clr ? 1'b0 : (udf_q | (pop & empty_q));
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
      pv_q    <= 1'b0;
    end else begin
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      af_q    <= af_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
      pv_q    <= pop_acc;
    end
  end

  assign full        = full_q;
  assign empty       = empty_q;
  assign almost_full = af_q;
  assign count       = count_q;
  assign overflow    = ovf_q;
  assign underflow   = udf_q;
  assign pop_valid   = pv_q;
  assign ram_wr_en   = push_acc;
  assign ram_wr_addr = wr_ptr[ADDR_WIDTH-1:0];
  assign ram_wr_data = push_data;
  assign ram_rd_en   = pop_acc;
  assign ram_rd_addr = rd_ptr[ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_dp_ram_fifo_ctrl.sv
// Directed bench for dp_ram_fifo_ctrl with a registered-read dual-port RAM model.
module tb_dp_ram_fifo_ctrl;

  localparam int AW = 3;
  localparam int DW = 32;

  logic          clk_in = 1'b0;
  logic          rst_n_in = 1'b0;
  logic          clr = 1'b0, push = 1'b0, pop = 1'b0;
  logic [DW-1:0] push_data = '0;
  logic          full, empty, almost_full, overflow, underflow, pop_valid;
  logic [AW:0]   count;
  logic          ram_wr_en, ram_rd_en;
  logic [AW-1:0] ram_wr_addr, ram_rd_addr;
  logic [DW-1:0] ram_wr_data;
  logic [DW-1:0] mem [0:7];
  logic [DW-1:0] dout;
  int checks = 0;
  int errors = 0;

  dp_ram_fifo_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .AF_LEVEL(6)) dut (
    .clk_in      (clk_in),
    .rst_n_in    (rst_n_in),
    .clr         (clr),
    .push        (push),
    .push_data   (push_data),
    .pop         (pop),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .count       (count),
    .overflow    (overflow),
    .underflow   (underflow),
    .pop_valid   (pop_valid),
    .ram_wr_en   (ram_wr_en),
    .ram_wr_addr (ram_wr_addr),
    .ram_wr_data (ram_wr_data),
    .ram_rd_en   (ram_rd_en),
    .ram_rd_addr (ram_rd_addr)
  );

  initial forever #5 clk_in = ~clk_in;

  always @(posedge clk_in) begin
    if (ram_wr_en) mem[ram_wr_addr] <= ram_wr_data;
    if (ram_rd_en) dout <= mem[ram_rd_addr];
  end

  task automatic cyc(input logic p, input logic [DW-1:0] d, input logic q);
    push = p; push_data = d; pop = q;
    @(posedge clk_in); #1;
    push = 1'b0; pop = 1'b0;
  endtask

  task automatic test_reset;
    rst_n_in = 1'b0;
    repeat (2) @(posedge clk_in);
    #1 rst_n_in = 1'b1;
    @(posedge clk_in); #1;
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b exp 1", empty); end
    checks++; if (full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", full); end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if (pop_valid !== 1'b0) begin errors++; $display("FAIL reset_pop_valid got %b exp 0", pop_valid); end
    checks++; if (ram_wr_en !== 1'b0 || ram_rd_en !== 1'b0) begin
      errors++; $display("FAIL reset_ram_en got wr %b rd %b exp 0 0", ram_wr_en, ram_rd_en);
    end
  endtask

  task automatic test_fill_drain;
    for (int i = 0; i < 8; i++) begin
      push = 1'b1; push_data = 32'hA0 + i; #1;
      checks++; if (ram_wr_en !== 1'b1 || ram_wr_addr !== AW'(i)) begin
        errors++; $display("FAIL fill_wr_cmd[%0d] got en %b addr %0d exp 1 %0d", i, ram_wr_en, ram_wr_addr, i);
      end
      @(posedge clk_in); #1;
      push = 1'b0;
      checks++; if (count !== 4'(i + 1)) begin errors++; $display("FAIL fill_count[%0d] got %0d exp %0d", i, count, i + 1); end
      checks++; if (almost_full !== (i + 1 >= 6)) begin
        errors++; $display("FAIL fill_af[%0d] got %b exp %b", i, almost_full, (i + 1 >= 6));
      end
    end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL fill_full got %b exp 1", full); end
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, '0, 1'b1);
      checks++; if (pop_valid !== 1'b1 || dout !== 32'hA0 + i) begin
        errors++; $display("FAIL drain_data[%0d] got pv %b data %h exp 1 %h", i, pop_valid, dout, 32'hA0 + i);
      end
    end
    cyc(1'b0, '0, 1'b0);
    checks++; if (empty !== 1'b1 || pop_valid !== 1'b0) begin
      errors++; $display("FAIL drain_end got empty %b pv %b exp 1 0", empty, pop_valid);
    end
  endtask

  task automatic test_wrap;
    for (int i = 0; i < 5; i++) cyc(1'b1, 32'h90 + i, 1'b0);
    for (int i = 0; i < 5; i++) cyc(1'b0, '0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      push = 1'b1; push_data = 32'hB0 + i; #1;
      checks++; if (ram_wr_addr !== AW'((5 + i) % 8)) begin
        errors++; $display("FAIL wrap_wr_addr[%0d] got %0d exp %0d", i, ram_wr_addr, (5 + i) % 8);
      end
      @(posedge clk_in); #1;
      push = 1'b0;
    end
    checks++; if (full !== 1'b1) begin errors++; $display("FAIL wrap_full got %b exp 1", full); end
    for (int i = 0; i < 8; i++) begin
      cyc(1'b0, '0, 1'b1);
      checks++; if (dout !== 32'hB0 + i) begin errors++; $display("FAIL wrap_data[%0d] got %h exp %h", i, dout, 32'hB0 + i); end
    end
    checks++; if (count !== 4'd0) begin errors++; $display("FAIL wrap_count got %0d exp 0", count); end
  endtask

  task automatic test_simultaneous;
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'hC0 + i, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 32'hC3 + i, 1'b1);
      checks++; if (count !== 4'd3 || dout !== 32'hC0 + i) begin
        errors++; $display("FAIL simul_mid[%0d] got count %0d data %h exp 3 %h", i, count, dout, 32'hC0 + i);
      end
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, '0, 1'b1);
      checks++; if (dout !== 32'hC4 + i) begin errors++; $display("FAIL simul_tail[%0d] got %h exp %h", i, dout, 32'hC4 + i); end
    end
    for (int i = 0; i < 8; i++) cyc(1'b1, 32'hD0 + i, 1'b0);
    cyc(1'b1, 32'hDF, 1'b1);
    checks++; if (count !== 4'd7 || overflow !== 1'b1) begin
      errors++; $display("FAIL simul_full got count %0d ovf %b exp 7 1", count, overflow);
    end
    checks++; if (pop_valid !== 1'b1 || dout !== 32'hD0) begin
      errors++; $display("FAIL simul_full_data got pv %b data %h exp 1 d0", pop_valid, dout);
    end
    for (int i = 0; i < 7; i++) cyc(1'b0, '0, 1'b1);
    checks++; if (dout !== 32'hD7 || empty !== 1'b1) begin
      errors++; $display("FAIL simul_full_drain got data %h empty %b exp d7 1", dout, empty);
    end
    cyc(1'b1, 32'hE0, 1'b1);
    checks++; if (count !== 4'd1 || underflow !== 1'b1 || pop_valid !== 1'b0) begin
      errors++; $display("FAIL simul_empty got count %0d udf %b pv %b exp 1 1 0", count, underflow, pop_valid);
    end
    cyc(1'b0, '0, 1'b1);
    checks++; if (dout !== 32'hE0 || empty !== 1'b1) begin
      errors++; $display("FAIL simul_empty_data got %h empty %b exp e0 1", dout, empty);
    end
  endtask

  task automatic test_error_clear;
    clr = 1'b1; cyc(1'b0, '0, 1'b0); clr = 1'b0;
    checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin
      errors++; $display("FAIL clr_flags_pre got ovf %b udf %b exp 0 0", overflow, underflow);
    end
    cyc(1'b0, '0, 1'b1);
    repeat (3) cyc(1'b0, '0, 1'b0);
    checks++; if (underflow !== 1'b1 || count !== 4'd0) begin
      errors++; $display("FAIL udf_sticky got udf %b count %0d exp 1 0", underflow, count);
    end
    for (int i = 0; i < 4; i++) cyc(1'b1, 32'h10 + i, 1'b0);
    clr = 1'b1; push = 1'b1; push_data = 32'h55; #1;
    checks++; if (ram_wr_en !== 1'b0) begin errors++; $display("FAIL clr_wr_en got %b exp 0", ram_wr_en); end
    @(posedge clk_in); #1;
    clr = 1'b0; push = 1'b0;
    checks++; if (count !== 4'd0 || empty !== 1'b1 || full !== 1'b0 || almost_full !== 1'b0) begin
      errors++; $display("FAIL clr_state got count %0d empty %b full %b af %b exp 0 1 0 0", count, empty, full, almost_full);
    end
    checks++; if (underflow !== 1'b0 || overflow !== 1'b0 || pop_valid !== 1'b0) begin
      errors++; $display("FAIL clr_err got udf %b ovf %b pv %b exp 0 0 0", underflow, overflow, pop_valid);
    end
    push = 1'b1; push_data = 32'h66; #1;
    checks++; if (ram_wr_addr !== 3'd0) begin errors++; $display("FAIL clr_wr_addr got %0d exp 0", ram_wr_addr); end
    @(posedge clk_in); #1;
    push = 1'b0;
  endtask

  task automatic test_reset_midstream;
    for (int i = 0; i < 5; i++) cyc(1'b1, 32'hF0 + i, 1'b0);
    cyc(1'b0, '0, 1'b1);
    checks++; if (count !== 4'd5 || pop_valid !== 1'b1) begin
      errors++; $display("FAIL mid_pre got count %0d pv %b exp 5 1", count, pop_valid);
    end
    push = 1'b1; push_data = 32'h77;
    #2 rst_n_in = 1'b0;
    #1;
    checks++; if (count !== 4'd0 || empty !== 1'b1 || pop_valid !== 1'b0) begin
      errors++; $display("FAIL mid_reset got count %0d empty %b pv %b exp 0 1 0", count, empty, pop_valid);
    end
    checks++; if (ram_wr_en !== 1'b0) begin errors++; $display("FAIL mid_reset_wr_en got %b exp 0", ram_wr_en); end
    rst_n_in = 1'b1; #1;
    checks++; if (ram_wr_en !== 1'b1 || ram_wr_addr !== 3'd0) begin
      errors++; $display("FAIL mid_first_push got en %b addr %0d exp 1 0", ram_wr_en, ram_wr_addr);
    end
    @(posedge clk_in); #1;
    push = 1'b0;
    cyc(1'b0, '0, 1'b1);
    checks++; if (dout !== 32'h77 || pop_valid !== 1'b1) begin
      errors++; $display("FAIL mid_readback got %h pv %b exp 77 1", dout, pop_valid);
    end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_wrap();
    test_simultaneous();
    test_error_clear();
    test_reset_midstream();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
